// File: rtl/hestoneuro_prod_accum.sv
// Sums num_terms signed products into a saturating ACC_W accumulator; result leaves on a valid/ready handshake.
// Latency: out_vld rises the cycle after the final beat. Backpressure: in_rdy stays low in HOLD until out_rdy takes the result.
module hestoneuro_prod_accum #(
  parameter int DIN_W = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [DIN_W-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [ACC_W-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_w;
  logic             sat_hi, sat_lo;
  logic             beat, start_ok, last_beat;

  // One guard bit: top two bits disagreeing means the signed sum left the ACC_W range.
  assign sum_w  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-DIN_W){in_data[DIN_W-1]}}, in_data};
  assign sat_hi = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
  assign sat_lo =  sum_w[ACC_W] & ~sum_w[ACC_W-1];

  assign beat      = in_vld && (state_q == S_ACCUM);
  assign last_beat = beat && (cnt_q == n_lat_q - CNT_W'(1));
  // A HOLD handoff with start pending launches the next job without an IDLE bubble.
  assign start_ok  = start && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_rdy));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    ovf_d   = ovf_q;
    if (start_ok) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      n_lat_d = num_terms;
      state_d = (num_terms == '0) ? S_HOLD : S_ACCUM;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sat_hi) begin
              acc_d = ACC_MAX;
              ovf_d = 1'b1;
            end else if (sat_lo) begin
              acc_d = ACC_MIN;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_w[ACC_W-1:0];
            end
            if (last_beat) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_rdy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_lat_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_rdy   = (state_q == S_ACCUM);
  assign out_vld  = (state_q == S_HOLD);
  assign busy     = (state_q != S_IDLE);
  assign out_data = acc_q;
  assign ovf      = ovf_q;

endmodule
